// File: rtl/adc_snap_capture_ctrl_pkg.sv
// Shared types and bit positions for the ADC snapshot capture sequencer.
package adc_snap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } snap_state_e;

    localparam int CTRL_ARM  = 0;
    localparam int CTRL_SRC  = 1;

    localparam int STAT_DONE = 31;
    localparam int STAT_TRIG = 30;
    localparam int STAT_WRAP = 29;

    function automatic int snap_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/adc_snap_capture_ctrl_if.sv
// Sample stream in, BRAM write port out; master is the capture controller side.
interface adc_snap_capture_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              trig_in;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (
        input  din, din_vld, trig_in,
        output bram_addr, bram_data, bram_we
    );

    modport slave (
        output din, din_vld, trig_in,
        input  bram_addr, bram_data, bram_we
    );
endinterface

// File: rtl/adc_snap_capture_ctrl_offset_sat.sv
// Clamps the signed trigger offset to [-DEPTH, 2^31-1]; anything further back
// than one full buffer could never be held anyway.
module snap_offset_sat
    import adc_snap_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        [31:0] raw,
    output logic signed [31:0] sat
);
    localparam int NEG_LIM = -snap_depth(ADDR_W);

    always_comb begin
        sat = $signed(raw);
        if ($signed(raw) < NEG_LIM) sat = NEG_LIM;
    end
endmodule

// File: rtl/adc_snap_capture_ctrl.sv
// Snapshot sequencer: arm -> trigger -> optional delay -> capture DEPTH samples.
// Pre-trigger ring capture (negative offsets, wrapped flag) exists only with SNAP_CTRL_PRETRIG_EN.
module adc_snap_capture_ctrl
    import adc_snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic [31:0]             ctrl,
    input  logic [31:0]             trig_offset,
    adc_snap_capture_ctrl_if.master bus,
    output logic [31:0]             status
);
    localparam int DEPTH = snap_depth(ADDR_W);

    snap_state_e        state, state_nxt;
    logic               arm_q;
    logic               arm_edge;
    logic               trig_hit;
    logic signed [31:0] off_sat, off_eff, off_q;
    logic [31:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0]  wr_addr, wr_addr_nxt;
    logic [ADDR_W-1:0]  trig_addr, trig_addr_nxt;
    logic               done, done_nxt;
    logic               trigd, trigd_nxt;
    logic               we_nxt;
    logic               unused_ctrl;
`ifdef SNAP_CTRL_PRETRIG_EN
    logic               wrapped, wrapped_nxt;
    logic signed [31:0] pre_rem;
`endif

    snap_offset_sat #(.ADDR_W(ADDR_W)) u_sat (
        .raw (trig_offset),
        .sat (off_sat)
    );

`ifdef SNAP_CTRL_PRETRIG_EN
    assign off_eff = off_sat;
    // post-trigger samples still owed once the trigger sample itself is written
    assign pre_rem = off_q + DEPTH - 1;
`else
    assign off_eff = off_sat[31] ? 32'sd0 : off_sat;
`endif

    assign arm_edge    = ctrl[CTRL_ARM] & ~arm_q;
    assign trig_hit    = ctrl[CTRL_SRC] | bus.trig_in;
    assign unused_ctrl = ^ctrl[31:2];

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        we_nxt        = 1'b0;
        wr_addr_nxt   = wr_addr;
        cnt_nxt       = cnt;
        done_nxt      = done;
        trigd_nxt     = trigd;
        trig_addr_nxt = trig_addr;
`ifdef SNAP_CTRL_PRETRIG_EN
        wrapped_nxt   = wrapped;
`endif
        if (arm_edge) begin
            state_nxt     = ST_ARMED;
            wr_addr_nxt   = '0;
            cnt_nxt       = '0;
            done_nxt      = 1'b0;
            trigd_nxt     = 1'b0;
            trig_addr_nxt = '0;
`ifdef SNAP_CTRL_PRETRIG_EN
            wrapped_nxt   = 1'b0;
`endif
        end else if (bus.din_vld) begin
            unique case (state)
                ST_ARMED: begin
`ifdef SNAP_CTRL_PRETRIG_EN
                    if (off_q[31]) begin
                        we_nxt      = 1'b1;
                        wr_addr_nxt = wr_addr + 1'b1;
                        if (&wr_addr) wrapped_nxt = 1'b1;
                    end
`endif
                    if (trig_hit) begin
                        trigd_nxt     = 1'b1;
                        trig_addr_nxt = wr_addr;
                        if (off_q == '0) begin
                            we_nxt      = 1'b1;
                            wr_addr_nxt = wr_addr + 1'b1;
                            cnt_nxt     = 32'(DEPTH - 1);
                            state_nxt   = ST_CAPTURE;
                        end
`ifdef SNAP_CTRL_PRETRIG_EN
                        else if (off_q[31]) begin
                            if (pre_rem <= 0) begin
                                done_nxt  = 1'b1;
                                state_nxt = ST_DONE;
                            end else begin
                                cnt_nxt   = $unsigned(pre_rem);
                                state_nxt = ST_CAPTURE;
                            end
                        end
`endif
                        else begin
                            cnt_nxt   = $unsigned(off_q);
                            state_nxt = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt == 32'd1) begin
                        cnt_nxt   = 32'(DEPTH);
                        state_nxt = ST_CAPTURE;
                    end else begin
                        cnt_nxt = cnt - 32'd1;
                    end
                end
                ST_CAPTURE: begin
                    we_nxt      = 1'b1;
                    wr_addr_nxt = wr_addr + 1'b1;
                    cnt_nxt     = cnt - 32'd1;
                    if (cnt == 32'd1) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            arm_q         <= 1'b0;
            off_q         <= '0;
            cnt           <= '0;
            wr_addr       <= '0;
            trig_addr     <= '0;
            done          <= 1'b0;
            trigd         <= 1'b0;
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_data <= '0;
        end else begin
            arm_q       <= ctrl[CTRL_ARM];
            cnt         <= cnt_nxt;
            wr_addr     <= wr_addr_nxt;
            trig_addr   <= trig_addr_nxt;
            done        <= done_nxt;
            trigd       <= trigd_nxt;
            bus.bram_we <= we_nxt;
            if (arm_edge) begin
                off_q         <= off_eff;
                bus.bram_addr <= '0;
            end else if (we_nxt) begin
                bus.bram_addr <= wr_addr;
                bus.bram_data <= bus.din;
            end
        end
    end

`ifdef SNAP_CTRL_PRETRIG_EN
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) wrapped <= 1'b0;
        else             wrapped <= wrapped_nxt;
    end
`endif

    always_comb begin
        status            = '0;
        status[STAT_DONE] = done;
        status[STAT_TRIG] = trigd;
`ifdef SNAP_CTRL_PRETRIG_EN
        status[STAT_WRAP] = wrapped;
`endif
        status[ADDR_W-1:0] = trig_addr;
    end
endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// Directed bench for adc_snap_capture_ctrl at ADDR_W=4 (16-entry buffer), ramp samples.
`timescale 1ns/1ps
module tb_adc_snap_capture_ctrl;
    localparam int          ADDR_W = 4;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h1000;

    logic        user_clk    = 1'b0;
    logic        user_rst_n  = 1'b0;
    logic [31:0] ctrl        = '0;
    logic [31:0] trig_offset = '0;
    logic [31:0] status;

    adc_snap_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .ctrl        (ctrl),
        .trig_offset (trig_offset),
        .bus         (bus),
        .status      (status)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [31:0] off;
        logic        src;
        int          trig;
        logic        gap;
        int          writes;
        logic [31:0] first;
        logic [31:0] last;
        int          last_addr;
        logic [31:0] stat;
    } vec_t;

    vec_t        vecs [7];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          writes;
    int          done_w;
    int          last_a;
    logic [31:0] first_d, last_d;
    logic [31:0] mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vld, input logic [31:0] d, input logic trg);
        bus.din_vld = vld;
        bus.din     = d;
        bus.trig_in = trg;
        @(posedge user_clk);
        #1;
    endtask

    task automatic observe();
        if (bus.bram_we) begin
            writes++;
            if (writes == 1) first_d = bus.bram_data;
            last_d = bus.bram_data;
            last_a = int'(bus.bram_addr);
            mem[bus.bram_addr] = bus.bram_data;
        end
        if (status[31] && done_w < 0) done_w = writes;
    endtask

    // Arm-edge cycle carries a valid sample with trigger asserted; it must be ignored.
    task automatic arm(input logic [31:0] off, input logic src, input string tag);
        ctrl        = {30'd0, src, 1'b0};
        trig_offset = off;
        cyc(1'b0, 32'hDEAD, 1'b1);
        ctrl[0] = 1'b1;
        cyc(1'b1, 32'hDEAD, 1'b1);
        trig_offset = 32'h7FFF_FFFF;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        writes  = 0;
        done_w  = -1;
        first_d = '0;
        last_d  = '0;
        last_a  = 0;
        chk({tag, ".arm_status"}, status, 32'h0);
        chk({tag, ".arm_we"}, {31'd0, bus.bram_we}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int i    = 0;
        int c    = 0;
        int post = 0;
        int bad  = 0;
        arm(v.off, v.src, tag);
        while (post < 4 && c < 1000) begin
            if (v.gap && (c % 2 == 1)) cyc(1'b0, 32'hBAD0, 1'b1);
            else begin
                cyc(1'b1, BASE + 32'(i), (i == v.trig));
                i++;
            end
            observe();
            if (done_w >= 0) post++;
            c++;
        end
        chk({tag, ".writes"}, 32'(writes), 32'(v.writes));
        chk({tag, ".done_at"}, 32'(done_w), 32'(v.writes));
        chk({tag, ".first"}, first_d, v.first);
        chk({tag, ".last"}, last_d, v.last);
        chk({tag, ".last_addr"}, 32'(last_a), 32'(v.last_addr));
        chk({tag, ".status"}, status, v.stat);
        for (int k = 0; k < DEPTH; k++)
            if (mem[(v.last_addr - k) & (DEPTH - 1)] !== v.last - 32'(k)) bad++;
        chk({tag, ".buffer"}, 32'(bad), 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'd0, 1'b1,   0, 1'b0, 16, 32'h1000, 32'h100F, 15, 32'hC000_0000};
        vecs[1] = '{32'd5, 1'b0, 100, 1'b0, 16, 32'h106A, 32'h1079, 15, 32'hC000_0000};
        vecs[2] = '{32'd1, 1'b1,   0, 1'b0, 16, 32'h1002, 32'h1011, 15, 32'hC000_0000};
        vecs[3] = '{32'd2, 1'b0,  10, 1'b1, 16, 32'h100D, 32'h101C, 15, 32'hC000_0000};
`ifdef SNAP_CTRL_PRETRIG_EN
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 40, 1'b0, 52, 32'h1000, 32'h1033, 3, 32'hE000_0008};
        vecs[5] = '{32'hFFFF_FF9C, 1'b0, 20, 1'b0, 21, 32'h1000, 32'h1014, 4, 32'hE000_0004};
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, 20, 1'b0, 35, 32'h1000, 32'h1022, 2, 32'hE000_0004};
`else
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 40, 1'b0, 16, 32'h1028, 32'h1037, 15, 32'hC000_0000};
        vecs[5] = '{32'hFFFF_FF9C, 1'b0, 20, 1'b0, 16, 32'h1014, 32'h1023, 15, 32'hC000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, 20, 1'b0, 16, 32'h1014, 32'h1023, 15, 32'hC000_0000};
`endif
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.trig_in = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        chk("reset.we", {31'd0, bus.bram_we}, 32'h0);
        chk("reset.addr", 32'(bus.bram_addr), 32'h0);
        chk("reset.data", bus.bram_data, 32'h0);
        chk("reset.status", status, 32'h0);
        user_rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("v%0d", n));

        // Re-arm after seven capture writes: everything restarts from address 0.
        arm(32'd0, 1'b1, "abort");
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, 32'h5000 + 32'(k), 1'b0);
            observe();
        end
        chk("abort.pre_writes", 32'(writes), 32'd7);
        chk("abort.pre_addr", 32'(last_a), 32'd6);
        run_vec(vecs[0], "abort");

        // Asynchronous reset between clock edges during capture.
        arm(32'd0, 1'b1, "rst");
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, BASE + 32'(k), 1'b0);
            observe();
        end
        chk("rst.pre_we", {31'd0, bus.bram_we}, 32'h1);
        #2 user_rst_n = 1'b0;
        #1;
        chk("rst.we", {31'd0, bus.bram_we}, 32'h0);
        chk("rst.addr", 32'(bus.bram_addr), 32'h0);
        chk("rst.data", bus.bram_data, 32'h0);
        chk("rst.status", status, 32'h0);
        ctrl = '0;
        cyc(1'b0, 32'h0, 1'b0);
        user_rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
